// File: rtl/mem_access.sv
// mem_access: single-port RAM access sequencer for byte/half/word loads and stores.
//
// Requests are accepted only in IDLE. Stores place the right-justified data into
// its byte lanes and drive an active-low lane mask. Loads read the containing
// word from a RAM with a one-cycle registered read, shift the addressed bytes
// down and sign- or zero-extend them.
//
// Optional feature macro: MEM_ACCESS_SPLIT_EN
//   defined   : misaligned half/word accesses run as two word accesses
//               (word A, then word A+4 modulo 2^ADDR_WIDTH)
//   undefined : misaligned half/word accesses complete immediately with error
//
// Ports
//   clk              : clock, rising edge
//   reset            : asynchronous reset, active low
//   req_valid        : start a request (sampled in IDLE only)
//   req_write        : 1 = store, 0 = load
//   req_size         : 0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned     : 1 = zero-extend load result, 0 = sign-extend
//   req_address      : byte address
//   req_wdata        : store data, right-justified
//   busy             : high in every state except IDLE
//   done             : one-cycle completion pulse
//   error            : valid with done; request rejected, nothing written
//   rdata            : extended load result, held until the next load completes
//   mem_address      : word-aligned RAM address
//   mem_data_out     : RAM write data, bytes in their lanes
//   mem_data_in      : RAM read data, one cycle after the address
//   mem_write_mask   : active-low byte-lane enables
//   mem_write_enable : RAM write strobe
//
// state    | meaning
// IDLE     | waiting for req_valid
// WRITE    | first (or only) word write
// WRITE2   | second word write of a split store
// READ     | address of first (or only) word on the RAM
// CAPTURE  | first word arrives from the RAM
// READ2    | address of second word of a split load
// CAPTURE2 | second word arrives from the RAM
// DONE     | done pulse, error reported
module mem_access #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_out,
  input  logic [31:0]           mem_data_in,
  output logic [3:0]            mem_write_mask,
  output logic                  mem_write_enable
);

`ifdef MEM_ACCESS_SPLIT_EN
  typedef enum logic [2:0] {
    IDLE, WRITE, WRITE2, READ, CAPTURE, READ2, CAPTURE2, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WRITE, READ, CAPTURE, DONE
  } state_t;
`endif

  state_t state_q, state_d;

  logic                  wr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;

  logic                  misaligned;
  logic                  illegal;
  logic [4:0]            sh;
  logic [3:0]            size_lanes;
  logic [ADDR_WIDTH-1:0] word_base;
  logic [31:0]           ld_word;
  logic [31:0]           ld_ext;

  assign misaligned = ((req_size == 2'd1) && req_address[0]) ||
                      ((req_size == 2'd2) && (req_address[1:0] != 2'b00));

`ifdef MEM_ACCESS_SPLIT_EN
  logic                  split_q;
  logic [31:0]           cap_q;
  logic [3:0]            wr_lanes1;
  logic [31:0]           wr_data1;
  logic [ADDR_WIDTH-1:0] word_next;

  assign illegal   = (req_size == 2'd3);
  // Lanes and data that spill past lane 3 of word A land from lane 0 of A+4.
  assign wr_lanes1 = size_lanes >> (3'd4 - {1'b0, addr_q[1:0]});
  assign wr_data1  = wdata_q >> (6'd32 - {1'b0, sh});
  assign word_next = word_base + ADDR_WIDTH'(4);
`else
  assign illegal   = (req_size == 2'd3) || misaligned;
`endif

  assign sh        = {addr_q[1:0], 3'b000};
  assign word_base = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign rdata     = rdata_q;

  always_comb begin
    case (size_q)
      2'd0:    size_lanes = 4'b0001;
      2'd1:    size_lanes = 4'b0011;
      default: size_lanes = 4'b1111;
    endcase
  end

  always_comb begin
    ld_word = mem_data_in >> sh;
`ifdef MEM_ACCESS_SPLIT_EN
    // Split load: the window of {second word, first word} starting at the offset.
    if (state_q == CAPTURE2) begin
      ld_word = (mem_data_in << (6'd32 - {1'b0, sh})) | (cap_q >> sh);
    end
`endif
  end

  always_comb begin
    case (size_q)
      2'd0:    ld_ext = uns_q ? {24'd0, ld_word[7:0]}  : {{24{ld_word[7]}}, ld_word[7:0]};
      2'd1:    ld_ext = uns_q ? {16'd0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    busy             = (state_q != IDLE);
    done             = 1'b0;
    error            = 1'b0;
    mem_address      = word_base;
    mem_data_out     = '0;
    mem_write_mask   = 4'b1111;
    mem_write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal)        state_d = DONE;
          else if (req_write) state_d = WRITE;
          else                state_d = READ;
        end
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        mem_write_mask   = ~(size_lanes << addr_q[1:0]);
        mem_data_out     = wdata_q << sh;
`ifdef MEM_ACCESS_SPLIT_EN
        state_d = split_q ? WRITE2 : DONE;
`else
        state_d = DONE;
`endif
      end
      READ:    state_d = CAPTURE;
`ifdef MEM_ACCESS_SPLIT_EN
      CAPTURE: state_d = split_q ? READ2 : DONE;
      WRITE2: begin
        mem_write_enable = 1'b1;
        mem_write_mask   = ~wr_lanes1;
        mem_data_out     = wr_data1;
        mem_address      = word_next;
        state_d          = DONE;
      end
      READ2: begin
        mem_address = word_next;
        state_d     = CAPTURE2;
      end
      CAPTURE2: begin
        mem_address = word_next;
        state_d     = DONE;
      end
`else
      CAPTURE: state_d = DONE;
`endif
      DONE: begin
        done    = 1'b1;
        error   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ACCESS_SPLIT_EN
      split_q <= 1'b0;
      cap_q   <= '0;
`endif
    end else begin
      if ((state_q == IDLE) && req_valid) begin
        wr_q    <= req_write;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        err_q   <= illegal;
        addr_q  <= req_address;
        wdata_q <= req_wdata;
`ifdef MEM_ACCESS_SPLIT_EN
        split_q <= misaligned;
`endif
      end
      if (state_q == CAPTURE) begin
`ifdef MEM_ACCESS_SPLIT_EN
        if (split_q) cap_q <= mem_data_in;
        else         rdata_q <= ld_ext;
`else
        rdata_q <= ld_ext;
`endif
      end
`ifdef MEM_ACCESS_SPLIT_EN
      if (state_q == CAPTURE2) rdata_q <= ld_ext;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  localparam int AW  = 12;
  localparam int MSZ = 1 << AW;
`ifdef MEM_ACCESS_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk, reset;
  logic          req_valid, req_write, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_address;
  logic [31:0]   req_wdata;
  logic          busy, done, error;
  logic [31:0]   rdata;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_out, mem_data_in;
  logic [3:0]    mem_write_mask;
  logic          mem_write_enable;

  mem_access #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_address(req_address), .req_wdata(req_wdata),
    .busy(busy), .done(done), .error(error), .rdata(rdata),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_write_mask(mem_write_mask), .mem_write_enable(mem_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(int i);
    return 8'((i * 73 + 29) ^ (i >> 5));
  endfunction

  // RAM environment: byte array, registered read, masked write.
  logic [7:0] ram_b [MSZ];
  logic       ram_load;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < MSZ; i++) ram_b[i] <= init_byte(i);
    end else if (mem_write_enable) begin
      for (int n = 0; n < 4; n++)
        if (!mem_write_mask[n]) ram_b[(int'(mem_address) & ~3) + n] <= mem_data_out[8*n +: 8];
    end
    for (int n = 0; n < 4; n++) mem_data_in[8*n +: 8] <= ram_b[(int'(mem_address) & ~3) + n];
  end

  // Reference byte memory and held load result.
  logic [7:0]  ref_mem [MSZ];
  logic [31:0] hold_rdata;

  int n_tests, n_fail;
  int obs_lat, obs_we;
  logic        obs_err;
  logic [31:0] obs_rdata;
  logic [3:0]  obs_mask [2];
  logic [AW-1:0] obs_addr [2];
  logic [31:0] obs_data [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_bits(logic [3:0] m);
    logic [31:0] b;
    b = '0;
    for (int n = 0; n < 4; n++) if (!m[n]) b[8*n +: 8] = 8'hFF;
    return b;
  endfunction

  task automatic check_idle();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_error", 32'(error), 32'd0);
    chk("idle_we", 32'(mem_write_enable), 32'd0);
    chk("idle_mask", 32'(mem_write_mask), 32'hF);
    chk("idle_rdata_hold", rdata, hold_rdata);
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    chk("rst_mask", 32'(mem_write_mask), 32'hF);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_wdata", mem_data_out, 32'd0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    check_idle();
  endtask

  task automatic run_req(input bit w, input logic [1:0] sz, input bit uns,
                         input logic [AW-1:0] addr, input logic [31:0] wd);
    int n, off, lat, beats, base, p;
    bit mis, err, split;
    logic [3:0]    emask [2];
    logic [31:0]   edata [2];
    logic [AW-1:0] eaddr [2];
    logic [31:0]   eload;

    n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off   = int'(addr) % 4;
    mis   = (sz == 2'd1 && (off % 2) == 1) || (sz == 2'd2 && off != 0);
    err   = (sz == 2'd3) || (mis && !SPLIT);
    split = mis && !err;
    lat   = err ? 1 : (w ? (split ? 3 : 2) : (split ? 5 : 3));
    beats = (w && !err) ? (split ? 2 : 1) : 0;
    base  = int'(addr) - off;
    eaddr[0] = AW'(base);
    eaddr[1] = AW'((base + 4) % MSZ);
    emask[0] = 4'hF; emask[1] = 4'hF;
    edata[0] = '0;   edata[1] = '0;
    eload = '0;
    for (int i = 0; i < n; i++) begin
      p = off + i;
      eload = eload | (32'(ref_mem[(int'(addr) + i) % MSZ]) << (8 * i));
      emask[p / 4][p % 4] = 1'b0;
      edata[p / 4][8*(p % 4) +: 8] = wd[8*i +: 8];
    end
    if (sz == 2'd0) eload = uns ? (eload & 32'hFF) : (eload[7] ? (eload | 32'hFFFF_FF00) : eload);
    if (sz == 2'd1) eload = uns ? (eload & 32'hFFFF) : (eload[15] ? (eload | 32'hFFFF_0000) : eload);
    if (w && !err)
      for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % MSZ] = wd[8*i +: 8];

    @(negedge clk);
    check_idle();
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_address = addr; req_wdata = wd;
    @(posedge clk);
    obs_lat = 0; obs_we = 0; obs_err = 1'b0; obs_rdata = '0;
    obs_mask[0] = 4'hF; obs_mask[1] = 4'hF;
    obs_addr[0] = '0;   obs_addr[1] = '0;
    obs_data[0] = '0;   obs_data[1] = '0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(k == lat));
      chk("error", 32'(error), 32'(k == lat && err));
      chk("addr_align", 32'(mem_address[1:0]), 32'd0);
      if (k <= beats) begin
        chk("we_on", 32'(mem_write_enable), 32'd1);
        chk("wr_addr", 32'(mem_address), 32'(eaddr[k-1]));
        chk("wr_mask", 32'(mem_write_mask), 32'(emask[k-1]));
        chk("wr_data", mem_data_out & lane_bits(emask[k-1]), edata[k-1]);
        obs_mask[k-1] = mem_write_mask;
        obs_addr[k-1] = mem_address;
        obs_data[k-1] = mem_data_out;
      end else begin
        chk("we_off", 32'(mem_write_enable), 32'd0);
        chk("mask_off", 32'(mem_write_mask), 32'hF);
      end
      if (!w && !err && k == 1) chk("rd_addr", 32'(mem_address), 32'(eaddr[0]));
      if (!w && split && k == 3) chk("rd_addr2", 32'(mem_address), 32'(eaddr[1]));
      if (mem_write_enable) obs_we++;
      if (done && obs_lat == 0) begin
        obs_lat = k; obs_err = error; obs_rdata = rdata;
      end
      if (k == lat && !w && !err) begin
        chk("rdata", rdata, eload);
        hold_rdata = eload;
      end
      // Garbage on the request port while busy must be ignored.
      req_valid    = 1'($urandom);
      req_write    = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_address  = AW'($urandom);
      req_wdata    = $urandom;
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    int rs;
    logic [1:0] rsz;
    n_tests = 0; n_fail = 0; hold_rdata = '0;
    req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_address = '0; req_wdata = '0;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);
    ram_load = 1'b1;
    reset = 1'b1;
    #3 reset = 1'b0;
    #10 check_reset_vals();
    @(negedge clk);
    ram_load = 1'b0;
    reset = 1'b1;

    // Byte store into lane 2.
    run_req(1, 2'd0, 0, AW'('h006), 32'h0000_00A5);
    chk("lit_sb_lat", 32'(obs_lat), 32'd2);
    chk("lit_sb_addr", 32'(obs_addr[0]), 32'h004);
    chk("lit_sb_mask", 32'(obs_mask[0]), 32'b1011);
    chk("lit_sb_lane2", 32'(obs_data[0][23:16]), 32'hA5);
    chk("lit_sb_err", 32'(obs_err), 32'd0);
    chk("lit_sb_we", 32'(obs_we), 32'd1);

    // Byte loads, signed and unsigned.
    run_req(1, 2'd0, 0, AW'('h006), 32'h0000_0080);
    run_req(0, 2'd0, 0, AW'('h006), 32'h0);
    chk("lit_lb_lat", 32'(obs_lat), 32'd3);
    chk("lit_lb_signed", obs_rdata, 32'hFFFF_FF80);
    run_req(0, 2'd0, 1, AW'('h006), 32'h0);
    chk("lit_lbu", obs_rdata, 32'h0000_0080);

    // Half store and unsigned half load.
    run_req(1, 2'd1, 0, AW'('h002), 32'h0000_BEEF);
    chk("lit_sh_mask", 32'(obs_mask[0]), 32'b0011);
    run_req(0, 2'd1, 1, AW'('h002), 32'h0);
    chk("lit_lhu", obs_rdata, 32'h0000_BEEF);

    // Illegal size.
    run_req(1, 2'd3, 0, AW'('h010), 32'h1234_5678);
    chk("lit_sz3_lat", 32'(obs_lat), 32'd1);
    chk("lit_sz3_err", 32'(obs_err), 32'd1);
    chk("lit_sz3_we", 32'(obs_we), 32'd0);

`ifdef MEM_ACCESS_SPLIT_EN
    // Word crossing the top of memory: lanes 1..3 at 0xFFC, lane 0 at 0x000.
    run_req(1, 2'd2, 0, AW'('hFFD), 32'h1122_3344);
    chk("lit_split_lat", 32'(obs_lat), 32'd3);
    chk("lit_split_addr0", 32'(obs_addr[0]), 32'hFFC);
    chk("lit_split_mask0", 32'(obs_mask[0]), 32'b0001);
    chk("lit_split_addr1", 32'(obs_addr[1]), 32'h000);
    chk("lit_split_mask1", 32'(obs_mask[1]), 32'b1110);
    chk("lit_split_we", 32'(obs_we), 32'd2);
    run_req(0, 2'd2, 0, AW'('hFFD), 32'h0);
    chk("lit_split_ld_lat", 32'(obs_lat), 32'd5);
    chk("lit_split_ld", obs_rdata, 32'h1122_3344);
`else
    run_req(0, 2'd2, 0, AW'('h001), 32'h0);
    chk("lit_mis_ld_lat", 32'(obs_lat), 32'd1);
    chk("lit_mis_ld_err", 32'(obs_err), 32'd1);
    run_req(1, 2'd2, 0, AW'('h001), 32'hDEAD_BEEF);
    chk("lit_mis_st_err", 32'(obs_err), 32'd1);
    chk("lit_mis_st_we", 32'(obs_we), 32'd0);
`endif

    // Randomized traffic concentrated on two small windows to force read-after-write hits.
    for (int r = 0; r < 400; r++) begin
      rs  = $urandom_range(0, 9);
      rsz = (rs < 3) ? 2'd0 : (rs < 6) ? 2'd1 : (rs < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 1) == 1) ra = AW'($urandom_range(0, 31));
      else                           ra = AW'(MSZ - 16 + int'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) ra = AW'($urandom);
      run_req(1'($urandom), rsz, 1'($urandom), ra, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Reset during the write cycle: strobe drops at once, no done, RAM untouched.
    @(negedge clk);
    check_idle();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_address = AW'('h100); req_wdata = 32'h0000_005A;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_we_before", 32'(mem_write_enable), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals();
    hold_rdata = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) idle_cycle();
    run_req(0, 2'd0, 1, AW'('h100), 32'h0);
    chk("rst_mid_no_write", obs_rdata, 32'(init_byte('h100)));

    for (int r = 0; r < 60; r++) begin
      ra = AW'($urandom_range(0, 63));
      run_req(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), ra, $urandom);
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
